// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the 5-stage RISC-V core: control-vector
// layout, control bundle type and default datapath widths.
package pipe_pkg;

  localparam int XLEN_DEFAULT       = 64;
  localparam int REG_ADDR_W_DEFAULT = 5;

  // Control vector layout; positions are fixed so later stages can forward
  // the vector unchanged.
  localparam int CTRL_W          = 10;
  localparam int CTRL_BRANCH     = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_TO_REG = 2;
  localparam int CTRL_OP_LSB     = 3;
  localparam int CTRL_OP_MSB     = 6;
  localparam int CTRL_MEM_WRITE  = 7;
  localparam int CTRL_ALU_SRC    = 8;
  localparam int CTRL_REG_WRITE  = 9;

  typedef logic [CTRL_W-1:0] ctrl_t;

  // Assemble the control vector from its individual fields.
  function automatic ctrl_t pack_ctrl(
    input logic       branch,
    input logic       mem_read,
    input logic       mem_to_reg,
    input logic [3:0] op,
    input logic       mem_write,
    input logic       alu_src,
    input logic       reg_write_en
  );
    ctrl_t c;
    c                                = {CTRL_W{1'b0}};
    c[CTRL_BRANCH]                   = branch;
    c[CTRL_MEM_READ]                 = mem_read;
    c[CTRL_MEM_TO_REG]               = mem_to_reg;
    c[CTRL_OP_MSB:CTRL_OP_LSB]       = op;
    c[CTRL_MEM_WRITE]                = mem_write;
    c[CTRL_ALU_SRC]                  = alu_src;
    c[CTRL_REG_WRITE]                = reg_write_en;
    return c;
  endfunction

endpackage

// File: rtl/pipe_reg_sc.sv
// Generic pipeline flop vector: async active-low reset, synchronous clear
// (higher priority) and load enable. Shared by IF/ID, ID/EX and EX/MEM.
module pipe_reg_sc #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Flop vector: reset > clear > load > hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= {W{1'b0}};
    end else if (clr) begin
      q <= {W{1'b0}};
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register. Captures the (possibly bubbled) control bundle,
// valid bit, operands and register indices; supports stall hold and flush.
// Optional build macro ID_EX_PERF_EN adds a saturating bubble_count port.
module id_ex_reg
  import pipe_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic                  branch_in,
  input  logic                  mem_read_in,
  input  logic                  mem_to_reg_in,
  input  logic                  mem_write_in,
  input  logic                  alu_src_in,
  input  logic                  reg_write_en_in,
  input  logic [3:0]            op_in,
  input  logic [XLEN-1:0]       pc_in,
  input  logic [XLEN-1:0]       rs1_data_in,
  input  logic [XLEN-1:0]       rs2_data_in,
  input  logic [XLEN-1:0]       imm_in,
  input  logic [REG_ADDR_W-1:0] rs1_in,
  input  logic [REG_ADDR_W-1:0] rs2_in,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  valid_out,
  output logic                  branch_out,
  output logic                  mem_read_out,
  output logic                  mem_to_reg_out,
  output logic                  mem_write_out,
  output logic                  alu_src_out,
  output logic                  reg_write_en_out,
  output logic [3:0]            op_out,
  output logic [XLEN-1:0]       pc_out,
  output logic [XLEN-1:0]       rs1_data_out,
  output logic [XLEN-1:0]       rs2_data_out,
  output logic [XLEN-1:0]       imm_out,
  output logic [REG_ADDR_W-1:0] rs1_out,
  output logic [REG_ADDR_W-1:0] rs2_out,
  output logic [REG_ADDR_W-1:0] rd_out
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]           bubble_count
`endif
);

  localparam int DATA_W = 4 * XLEN;
  localparam int IDX_W  = 3 * REG_ADDR_W;

  ctrl_t                  ctrl_in_s;
  ctrl_t                  ctrl_q_s;
  logic                   valid_q_s;
  logic [DATA_W-1:0]      data_q_s;
  logic [IDX_W-1:0]       idx_q_s;
  logic                   load_en_s;

  assign ctrl_in_s = pack_ctrl(branch_in, mem_read_in, mem_to_reg_in, op_in,
                               mem_write_in, alu_src_in, reg_write_en_in);
  assign load_en_s = ~stall;

  // Valid bit plus control bundle share one register group so a flush
  // clears both together.
  pipe_reg_sc #(.W(CTRL_W + 1)) u_ctrl_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .en    (load_en_s),
    .d     ({valid_in, ctrl_in_s}),
    .q     ({valid_q_s, ctrl_q_s})
  );

  pipe_reg_sc #(.W(DATA_W)) u_data_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .en    (load_en_s),
    .d     ({pc_in, rs1_data_in, rs2_data_in, imm_in}),
    .q     (data_q_s)
  );

  pipe_reg_sc #(.W(IDX_W)) u_idx_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .en    (load_en_s),
    .d     ({rs1_in, rs2_in, rd_in}),
    .q     (idx_q_s)
  );

  assign valid_out        = valid_q_s;
  assign branch_out       = ctrl_q_s[CTRL_BRANCH];
  assign mem_read_out     = ctrl_q_s[CTRL_MEM_READ];
  assign mem_to_reg_out   = ctrl_q_s[CTRL_MEM_TO_REG];
  assign op_out           = ctrl_q_s[CTRL_OP_MSB:CTRL_OP_LSB];
  assign mem_write_out    = ctrl_q_s[CTRL_MEM_WRITE];
  assign alu_src_out      = ctrl_q_s[CTRL_ALU_SRC];
  assign reg_write_en_out = ctrl_q_s[CTRL_REG_WRITE];
  assign {pc_out, rs1_data_out, rs2_data_out, imm_out} = data_q_s;
  assign {rs1_out, rs2_out, rd_out}                    = idx_q_s;

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_count_r;
  logic        bubble_evt_s;

  // A bubble enters EX on a flush, or on a load of an all-zero control bundle.
  always_comb begin
    bubble_evt_s = 1'b0;
    if (flush) begin
      bubble_evt_s = 1'b1;
    end else if (!stall && (ctrl_in_s == {CTRL_W{1'b0}})) begin
      bubble_evt_s = 1'b1;
    end else begin
      bubble_evt_s = 1'b0;
    end
  end

  // Saturating bubble counter, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count_r <= 32'h0000_0000;
    end else if (bubble_evt_s && (bubble_count_r != 32'hFFFF_FFFF)) begin
      bubble_count_r <= bubble_count_r + 32'd1;
    end else begin
      bubble_count_r <= bubble_count_r;
    end
  end

  assign bubble_count = bubble_count_r;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg (default build; perf counter checks are
// included when ID_EX_PERF_EN is defined).
module tb_id_ex_reg;

  localparam int XLEN = 64;
  localparam int RW   = 5;

  typedef struct packed {
    logic            valid;
    logic [9:0]      ctrl;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1d;
    logic [XLEN-1:0] rs2d;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   rs1;
    logic [RW-1:0]   rs2;
    logic [RW-1:0]   rd;
    logic [31:0]     bc;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n, stall, flush, valid_in;
  logic branch_in, mem_read_in, mem_to_reg_in, mem_write_in, alu_src_in, reg_write_en_in;
  logic [3:0] op_in;
  logic [XLEN-1:0] pc_in, rs1_data_in, rs2_data_in, imm_in;
  logic [RW-1:0] rs1_in, rs2_in, rd_in;
  logic valid_out, branch_out, mem_read_out, mem_to_reg_out, mem_write_out, alu_src_out, reg_write_en_out;
  logic [3:0] op_out;
  logic [XLEN-1:0] pc_out, rs1_data_out, rs2_data_out, imm_out;
  logic [RW-1:0] rs1_out, rs2_out, rd_out;
`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_count;
`endif

  int    n_cmp = 0;
  int    n_err = 0;
  snap_t model;
  snap_t sb_q[$];

  always #5 clk = ~clk;

  id_ex_reg #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .branch_in(branch_in), .mem_read_in(mem_read_in), .mem_to_reg_in(mem_to_reg_in),
    .mem_write_in(mem_write_in), .alu_src_in(alu_src_in), .reg_write_en_in(reg_write_en_in),
    .op_in(op_in), .pc_in(pc_in), .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .imm_in(imm_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
    .valid_out(valid_out), .branch_out(branch_out), .mem_read_out(mem_read_out),
    .mem_to_reg_out(mem_to_reg_out), .mem_write_out(mem_write_out), .alu_src_out(alu_src_out),
    .reg_write_en_out(reg_write_en_out), .op_out(op_out), .pc_out(pc_out),
    .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out), .imm_out(imm_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out)
`ifdef ID_EX_PERF_EN
    , .bubble_count(bubble_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Control vector in the documented bit order, built from the bench inputs.
  function automatic logic [9:0] in_ctrl();
    return {reg_write_en_in, alu_src_in, mem_write_in, op_in, mem_to_reg_in, mem_read_in, branch_in};
  endfunction

  // Pop one expectation and compare it with the current DUT outputs.
  task automatic compare(input string tag);
    snap_t e;
    logic [9:0] oc;
    if (sb_q.size() == 0) begin
      n_cmp++; n_err++;
      $error("FAIL %s_sb: observed empty queue expected entry", tag);
      return;
    end
    e  = sb_q.pop_front();
    oc = {reg_write_en_out, alu_src_out, mem_write_out, op_out, mem_to_reg_out, mem_read_out, branch_out};
    chk({tag, "_valid"}, {63'd0, valid_out}, {63'd0, e.valid});
    chk({tag, "_ctrl"}, {54'd0, oc}, {54'd0, e.ctrl});
    chk({tag, "_pc"}, pc_out, e.pc);
    chk({tag, "_rs1d"}, rs1_data_out, e.rs1d);
    chk({tag, "_rs2d"}, rs2_data_out, e.rs2d);
    chk({tag, "_imm"}, imm_out, e.imm);
    chk({tag, "_idx"}, {49'd0, rs1_out, rs2_out, rd_out}, {49'd0, e.rs1, e.rs2, e.rd});
    chk({tag, "_inv"}, {63'd0, (valid_out == 1'b0) && ({reg_write_en_out, mem_write_out, mem_read_out, branch_out} != 4'b0000)}, 64'd0);
`ifdef ID_EX_PERF_EN
    chk({tag, "_bc"}, {32'd0, bubble_count}, {32'd0, e.bc});
`endif
  endtask

  // Advance the model one edge (flush > stall > load), push, clock, compare.
  task automatic step(input string tag);
    logic [9:0] c;
    c = in_ctrl();
    if (flush || (!stall && c == 10'd0)) begin
      if (model.bc != 32'hFFFF_FFFF) model.bc = model.bc + 32'd1;
    end
    if (flush) begin
      model = '{valid: 1'b0, ctrl: 10'd0, pc: 64'd0, rs1d: 64'd0, rs2d: 64'd0, imm: 64'd0,
                rs1: 5'd0, rs2: 5'd0, rd: 5'd0, bc: model.bc};
    end else if (!stall) begin
      model = '{valid: valid_in, ctrl: c, pc: pc_in, rs1d: rs1_data_in, rs2d: rs2_data_in,
                imm: imm_in, rs1: rs1_in, rs2: rs2_in, rd: rd_in, bc: model.bc};
    end
    sb_q.push_back(model);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic clear_inputs();
    {stall, flush, valid_in, branch_in, mem_read_in, mem_to_reg_in, mem_write_in, alu_src_in, reg_write_en_in} = 9'd0;
    op_in = 4'd0; pc_in = 64'd0; rs1_data_in = 64'd0; rs2_data_in = 64'd0; imm_in = 64'd0;
    rs1_in = 5'd0; rs2_in = 5'd0; rd_in = 5'd0;
  endtask

  initial begin
    model = '0;
    clear_inputs();
    // 1. reset for 3 cycles, then a first load
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb_q.push_back(model);
    compare("reset");
    rst_n = 1'b1;
    pc_in = 64'h1000; rd_in = 5'd5; reg_write_en_in = 1'b1; op_in = 4'b0010; valid_in = 1'b1;
    step("load1");

    // 2. stall hold for 4 cycles while pc_in advances
    pc_in = 64'h2000; rs1_data_in = 64'hDEAD_BEEF_0123_4567; imm_in = 64'hFFFF_FFFF_FFFF_FFF0;
    mem_read_in = 1'b1; branch_in = 1'b1; rs2_in = 5'd31;
    step("load2");
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc_in = pc_in + 64'd4;
      rs1_data_in = rs1_data_in ^ 64'hFFFF;
      step("stall");
    end
    stall = 1'b0;
    step("unstall");

    // 3. flush beats simultaneous stall
    stall = 1'b1; flush = 1'b1; mem_write_in = 1'b1;
    step("flush_stall");
    stall = 1'b0; flush = 1'b0;

    // 4. upstream bubble: controls all zero but valid
    clear_inputs();
    valid_in = 1'b1; rs1_in = 5'd7; pc_in = 64'h3000;
    step("bubble");

    // assorted loads with varied patterns
    for (int i = 0; i < 4; i++) begin
      {branch_in, mem_read_in, mem_to_reg_in, mem_write_in, alu_src_in, reg_write_en_in} = 6'($urandom);
      op_in = 4'($urandom); valid_in = 1'b1;
      pc_in = {$urandom, $urandom}; rs1_data_in = {$urandom, $urandom};
      rs2_data_in = {$urandom, $urandom}; imm_in = {$urandom, $urandom};
      rs1_in = 5'($urandom); rs2_in = 5'($urandom); rd_in = 5'($urandom);
      step("rand");
    end

    // 5. async reset pulse between edges while stalled
    stall = 1'b1;
    step("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    model = '0;
    sb_q.push_back(model);
    compare("async_rst");
    #1;
    rst_n = 1'b1;
    step("post_rst_stall");
    stall = 1'b0;
    step("post_rst_load");

`ifdef ID_EX_PERF_EN
    // 6. counter saturation
    #1;
    force dut.bubble_count_r = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_count_r;
    model.bc = 32'hFFFF_FFFE;
    flush = 1'b1;
    repeat (3) step("sat");
    flush = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
